dma_copy: RTL and testbench

- Word-granular memory-to-memory copy engine on the SoC valid/ready memory bus.
- Has a responder port for CPU-programmed registers, decoded by the SoC address decoder at dma_base_addr.
- Has an initiator port that issues read/write requests into the same decoder as a second master, behind an arbiter.
- Raises a level interrupt on completion.

---
 rtl/dma_copy_pkg.sv | 16 +
 rtl/dma_copy_regfile.sv | 69 ++++++
 rtl/dma_copy.sv | 89 ++++++++
 tb/tb_dma_copy.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_copy_pkg.sv
// dma_copy_pkg: address window, register offsets, CTRL bit indices and FSM states for dma_copy
package dma_copy_pkg;
  localparam logic [31:0] dma_base_addr = 32'h0300_0000;
  localparam logic [31:0] dma_top_addr = dma_base_addr + 32'h0000_000F;
  localparam logic [3:0] DMA_SRC = 4'h0;
  localparam logic [3:0] DMA_DST = 4'h4;
  localparam logic [3:0] DMA_LEN = 4'h8;
  localparam logic [3:0] DMA_CTRL = 4'hC;
  localparam int CTRL_START = 0;
  localparam int CTRL_BUSY = 1;
  localparam int CTRL_DONE = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_ABORT = 4;
  localparam int CTRL_ABORTED = 5;
  typedef enum logic [1:0] {IDLE, READ, WRITE} dma_state_t;
endpackage

// File: rtl/dma_copy_regfile.sv
// dma_copy_regfile: config-port responder, SRC/DST/LEN/CTRL storage and START/ABORT pulses
// ABORT support is compiled in with DMA_ABORT_EN.
module dma_regfile
  import dma_copy_pkg::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dma_valid,
  input  logic                dma_instr,
  input  logic [31:0]         dma_addr,
  input  logic [31:0]         dma_wdata,
  input  logic [3:0]          dma_wstrb,
  output logic [31:0]         dma_rdata,
  output logic                dma_ready,
  output logic                dma_irq,
  input  logic                busy,
  input  logic                done_set,
  input  logic                aborted_set,
  output logic [31:0]         src,
  output logic [31:0]         dst,
  output logic [LEN_BITS-1:0] len,
  output logic                start,
  output logic                abort
);
  logic wr, wr_ctrl, irq_en, done, aborted, unused_ok;
  logic [1:0] sel;
  logic [31:0] rd;
  assign unused_ok = ^{dma_instr, dma_addr[31:4], dma_addr[1:0]};
  assign sel = dma_addr[3:2];
  assign wr = dma_valid & |dma_wstrb;
  assign wr_ctrl = wr && sel == DMA_CTRL[3:2];
  assign start = wr_ctrl & dma_wdata[CTRL_START] & ~busy;
`ifdef DMA_ABORT_EN
  assign abort = wr_ctrl & dma_wdata[CTRL_ABORT] & busy;
`else
  assign abort = 1'b0;
`endif
  always_comb
    rd = sel == DMA_SRC[3:2] ? src :
         sel == DMA_DST[3:2] ? dst :
         sel == DMA_LEN[3:2] ? {{(32-LEN_BITS){1'b0}}, len} :
         {26'b0, aborted, 1'b0, irq_en, done, busy, 1'b0};
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dma_ready <= 1'b0;
      dma_rdata <= '0;
      dma_irq <= 1'b0;
      src <= '0;
      dst <= '0;
      len <= '0;
      irq_en <= 1'b0;
      done <= 1'b0;
      aborted <= 1'b0;
    end else begin
      dma_ready <= dma_valid;
      dma_rdata <= dma_valid ? rd : '0;
      if (wr && !busy && sel == DMA_SRC[3:2]) src <= {dma_wdata[31:2], 2'b00};
      if (wr && !busy && sel == DMA_DST[3:2]) dst <= {dma_wdata[31:2], 2'b00};
      if (wr && !busy && sel == DMA_LEN[3:2]) len <= dma_wdata[LEN_BITS-1:0];
      if (wr_ctrl) irq_en <= dma_wdata[CTRL_IRQ_EN];
      // a completion landing on a W1C write keeps the flag set
      done <= done_set | (done & ~(wr_ctrl & dma_wdata[CTRL_DONE]));
      aborted <= aborted_set | (aborted & ~(wr_ctrl & dma_wdata[CTRL_ABORTED]));
      dma_irq <= done & irq_en;
    end
  end
endmodule

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine with CPU config port and level IRQ
// Optional abort support via DMA_ABORT_EN (see dma_regfile).
module dma_copy
  import dma_copy_pkg::*;
#(
  parameter int LEN_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        dma_valid,
  input  logic        dma_instr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [3:0]  dma_wstrb,
  output logic [31:0] dma_rdata,
  output logic        dma_ready,
  output logic        memory_valid,
  output logic        memory_instr,
  output logic [31:0] memory_addr,
  output logic [31:0] memory_wdata,
  output logic [3:0]  memory_wstrb,
  input  logic [31:0] memory_rdata,
  input  logic        memory_ready,
  output logic        dma_irq
);
  dma_state_t state, state_nx;
  logic [31:0] src, dst, src_ptr, dst_ptr, data;
  logic [LEN_BITS-1:0] len, count;
  logic start, abort, abort_pend, gap, hs, last, done_set, aborted_set;
  dma_regfile #(.LEN_BITS(LEN_BITS)) u_regs (
    .clock(clock), .reset(reset), .dma_valid(dma_valid), .dma_instr(dma_instr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready), .dma_irq(dma_irq),
    .busy(state != IDLE), .done_set(done_set), .aborted_set(aborted_set),
    .src(src), .dst(dst), .len(len), .start(start), .abort(abort)
  );
  // the gap cycle after every response keeps one ready from being counted twice
  assign memory_valid = state != IDLE && !gap;
  assign memory_instr = 1'b0;
  assign memory_addr = !memory_valid ? '0 : state == READ ? src_ptr : dst_ptr;
  assign memory_wdata = memory_valid && state == WRITE ? data : '0;
  assign memory_wstrb = memory_valid && state == WRITE ? 4'b1111 : 4'b0000;
  assign hs = memory_valid & memory_ready;
  assign last = count == LEN_BITS'(1) || abort_pend;
  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    aborted_set = 1'b0;
    unique case (state)
      IDLE: begin
        state_nx = start && len != '0 ? READ : IDLE;
        done_set = start && len == '0;
      end
      READ: state_nx = hs ? WRITE : READ;
      WRITE: begin
        state_nx = hs ? (last ? IDLE : READ) : WRITE;
        done_set = hs && last && !abort_pend;
        aborted_set = hs && abort_pend;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gap <= 1'b0;
      abort_pend <= 1'b0;
      src_ptr <= '0;
      dst_ptr <= '0;
      count <= '0;
      data <= '0;
    end else begin
      state <= state_nx;
      gap <= hs;
      abort_pend <= state_nx == IDLE ? 1'b0 : abort_pend | abort;
      if (state == IDLE && start) begin
        src_ptr <= src;
        dst_ptr <= dst;
        count <= len;
      end
      if (state == READ && hs) data <= memory_rdata;
      if (state == WRITE && hs) begin
        src_ptr <= src_ptr + 32'd4;
        dst_ptr <= dst_ptr + 32'd4;
        count <= count - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: table-driven copy vectors plus hand sequences, checked by a memory-side scoreboard
module tb_dma_copy;
  import dma_copy_pkg::*;
  logic clock = 1'b0, reset = 1'b0;
  logic dma_valid = 1'b0, dma_instr = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [3:0] dma_wstrb = '0;
  logic [31:0] dma_rdata, memory_addr, memory_wdata;
  logic dma_ready, memory_valid, memory_instr, dma_irq;
  logic [3:0] memory_wstrb;
  logic [31:0] memory_rdata = '0;
  logic memory_ready = 1'b0;

  dma_copy #(.LEN_BITS(16)) dut (
    .clock(clock), .reset(reset), .dma_valid(dma_valid), .dma_instr(dma_instr),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_wstrb(dma_wstrb),
    .dma_rdata(dma_rdata), .dma_ready(dma_ready), .memory_valid(memory_valid),
    .memory_instr(memory_instr), .memory_addr(memory_addr), .memory_wdata(memory_wdata),
    .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata), .memory_ready(memory_ready),
    .dma_irq(dma_irq)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] a, d; } wr_t;
  typedef struct { logic [31:0] src, dst; int len, lat; logic irq_en; logic [31:0] exp_ctrl; } vec_t;

  int total = 0, bad = 0;
  int lat = 0, wcnt = 0, pairs = 0, rd_cnt = 0;
  logic valid_seen = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] rq [$];
  wr_t wq [$];
  logic [31:0] h_addr, h_wdata;
  logic [3:0] h_wstrb;

  function automatic void chk(string n, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  // memory responder and scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      memory_ready = 1'b0;
      wcnt = 0;
    end else if (memory_ready) begin
      memory_ready = 1'b0;
      wcnt = 0;
      chk("gap", memory_valid, 0);
    end else if (memory_valid) begin
      valid_seen = 1'b1;
      if (wcnt == 0) begin
        h_addr = memory_addr;
        h_wdata = memory_wdata;
        h_wstrb = memory_wstrb;
      end else chk("stable", {memory_addr, memory_wdata, memory_wstrb}, {h_addr, h_wdata, h_wstrb});
      if (wcnt >= lat) begin
        memory_ready = 1'b1;
        pairs++;
        if (memory_wstrb == 4'b0000) begin
          rd_cnt++;
          if (rq.size() == 0) chk("extra_read", memory_addr, 32'hxxxx_xxxx);
          else chk("read_addr", memory_addr, rq.pop_front());
          memory_rdata = mem.exists(memory_addr) ? mem[memory_addr] : 32'h0;
        end else begin
          chk("wstrb", memory_wstrb, 4'b1111);
          if (wq.size() == 0) chk("extra_write", memory_addr, 32'hxxxx_xxxx);
          else begin
            wr_t e;
            e = wq.pop_front();
            chk("write", {memory_addr, memory_wdata}, {e.a, e.d});
          end
          mem[memory_addr] = memory_wdata;
        end
      end
      wcnt++;
    end
  end

  task automatic cfg(input logic [3:0] a, input logic [31:0] d, input logic wr, output logic [31:0] r);
    dma_valid = 1'b1;
    dma_addr = {28'h0, a};
    dma_wdata = d;
    dma_wstrb = wr ? 4'hF : 4'h0;
    @(posedge clock);
    @(negedge clock);
    dma_valid = 1'b0;
    dma_wstrb = 4'h0;
    chk("cfg_ready", dma_ready, 1);
    r = dma_rdata;
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] r;
    cfg(a, d, 1'b1, r);
  endtask

  task automatic load(input logic [31:0] s, input logic [31:0] d, input int n, input logic [31:0] salt);
    for (int i = 0; i < n; i++) begin
      logic [31:0] sa, da, v;
      sa = s + 32'(4 * i);
      da = d + 32'(4 * i);
      v = salt + 32'(i + 1) * 32'h11;
      mem[sa] = v;
      rq.push_back(sa);
      wq.push_back('{da, v});
    end
    pairs = 0;
    rd_cnt = 0;
  endtask

  task automatic wait_idle(output logic [31:0] c);
    int k;
    k = 0;
    do begin
      cfg(DMA_CTRL, 32'h0, 1'b0, c);
      k++;
    end while (c[CTRL_BUSY] && k < 3000);
    if (c[CTRL_BUSY]) chk("timeout_busy", c[CTRL_BUSY], 0);
  endtask

  task automatic end_copy(string n, int len, logic [31:0] exp_ctrl, logic exp_irq);
    logic [31:0] c;
    wait_idle(c);
    cfg(DMA_CTRL, 32'h0, 1'b0, c);
    chk({n, "_ctrl"}, c, exp_ctrl);
    chk({n, "_irq"}, dma_irq, exp_irq);
    chk({n, "_pairs"}, pairs, 2 * len);
    chk({n, "_qempty"}, rq.size() + wq.size(), 0);
    wr_reg(DMA_CTRL, 32'h4 | 32'h20);
    @(negedge clock);
    chk({n, "_irq_clr"}, dma_irq, 0);
  endtask

  vec_t vecs [4];
  logic [31:0] r;

  initial begin
    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 4, 0, 1'b1, 32'hC};
    vecs[1] = '{32'hFFFF_FFF8, 32'h0000_1000, 3, 5, 1'b0, 32'h4};
    vecs[2] = '{32'h0000_2000, 32'h0000_3004, 7, 1, 1'b1, 32'hC};
    vecs[3] = '{32'h0000_0040, 32'h0000_8000, 1, 2, 1'b0, 32'h4};

    // reset with random config traffic
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      dma_valid = 1'($urandom);
      dma_addr = $urandom & 32'hC;
      dma_wdata = $urandom;
      dma_wstrb = 4'($urandom);
      #1;
      chk("rst_out", {dma_ready, dma_rdata, memory_valid, memory_wstrb, memory_addr, memory_wdata, dma_irq}, 0);
    end
    dma_valid = 1'b0;
    dma_wstrb = 4'h0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    cfg(DMA_CTRL, 32'h0, 1'b0, r);
    chk("rst_ctrl", r, 0);
    chk("rst_idle_rdata", dma_rdata, r);
    @(negedge clock);
    chk("rdata_idle", dma_rdata, 0);

    // table-driven copies
    for (int v = 0; v < 4; v++) begin
      lat = vecs[v].lat;
      load(vecs[v].src, vecs[v].dst, vecs[v].len, 32'(v) << 16);
      wr_reg(DMA_SRC, vecs[v].src);
      wr_reg(DMA_DST, vecs[v].dst);
      wr_reg(DMA_LEN, 32'(vecs[v].len));
      wr_reg(DMA_CTRL, {28'h0, vecs[v].irq_en, 3'b001});
      end_copy($sformatf("vec%0d", v), vecs[v].len, vecs[v].exp_ctrl, vecs[v].irq_en);
      for (int i = 0; i < vecs[v].len; i++)
        chk("dst_mem", mem[vecs[v].dst + 32'(4 * i)], (32'(v) << 16) + 32'(i + 1) * 32'h11);
    end

    // re-issued START repeats the last programmed copy
    cfg(DMA_SRC, 32'h0, 1'b0, r);
    chk("src_kept", r, vecs[3].src);
    lat = 0;
    load(vecs[3].src, vecs[3].dst, vecs[3].len, 32'h00AB_0000);
    wr_reg(DMA_CTRL, 32'h1);
    end_copy("restart", vecs[3].len, 32'h4, 1'b0);

    // zero length: DONE, no bus traffic
    valid_seen = 1'b0;
    pairs = 0;
    wr_reg(DMA_LEN, 32'h0);
    wr_reg(DMA_CTRL, 32'h1);
    cfg(DMA_CTRL, 32'h0, 1'b0, r);
    chk("zero_ctrl", r, 32'h4);
    repeat (5) @(negedge clock);
    chk("zero_no_valid", valid_seen, 0);
    wr_reg(DMA_CTRL, 32'h4);

    // busy protection
    lat = 3;
    load(32'h0000_5000, 32'h0000_6000, 4, 32'h0077_0000);
    wr_reg(DMA_SRC, 32'h0000_5000);
    wr_reg(DMA_DST, 32'h0000_6000);
    wr_reg(DMA_LEN, 32'd4);
    wr_reg(DMA_CTRL, 32'h1);
    wr_reg(DMA_LEN, 32'd9);
    wr_reg(DMA_CTRL, 32'h1);
    cfg(DMA_LEN, 32'h0, 1'b0, r);
    chk("busy_len", r, 32'd4);
    end_copy("busy", 4, 32'h4, 1'b0);

`ifdef DMA_ABORT_EN
    // abort during the third read
    begin
      int k;
      lat = 8;
      load(32'h0000_A000, 32'h0000_B000, 3, 32'h0099_0000);
      wr_reg(DMA_SRC, 32'h0000_A000);
      wr_reg(DMA_DST, 32'h0000_B000);
      wr_reg(DMA_LEN, 32'd100);
      wr_reg(DMA_CTRL, 32'h9);
      k = 0;
      while (!(rd_cnt == 2 && memory_valid && memory_wstrb == 4'h0) && k < 500) begin
        @(negedge clock);
        k++;
      end
      chk("abort_reach_read3", k < 500, 1);
      wr_reg(DMA_CTRL, 32'h18);
      end_copy("abort", 3, 32'h28, 1'b0);
    end
`endif

    // reset mid-transfer drops memory_valid at once
    begin
      int k;
      lat = 10;
      load(32'h0000_C000, 32'h0000_D000, 4, 32'h0);
      wr_reg(DMA_SRC, 32'h0000_C000);
      wr_reg(DMA_DST, 32'h0000_D000);
      wr_reg(DMA_LEN, 32'd4);
      wr_reg(DMA_CTRL, 32'h1);
      k = 0;
      while (!memory_valid && k < 50) begin
        @(negedge clock);
        k++;
      end
      chk("mid_valid_seen", memory_valid, 1);
      #2 reset = 1'b0;
      #1 chk("mid_rst", {memory_valid, memory_addr, memory_wstrb}, 0);
      rq.delete();
      wq.delete();
      @(negedge clock);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      chk("post_rst_valid", memory_valid, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
